// File: rtl/shreg_pkg.sv
// Shared state type and sizing helpers for the parallel-to-serial stage
// that feeds the downstream 8-stage shift register.
package shreg_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_bits(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shreg_bit_counter.sv
// Bit-position counter for the serializer: saturates at WIDTH-1 instead of
// wrapping, and flags the terminal position with a registered at_last.
module shreg_bit_counter
    import shreg_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int CW    = cnt_bits(WIDTH)
) (
    input  logic          C,
    input  logic          R,
    input  logic          load,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          at_last
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CW'(WIDTH - 1))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // The terminal flag is computed from the next count so it lines up with cnt.
    always_ff @(posedge C) begin
        if (R) begin
            cnt_q     <= '0;
            at_last_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            at_last_q <= (cnt_d == CW'(WIDTH - 1));
        end
    end

    assign cnt     = cnt_q;
    assign at_last = at_last_q;

endmodule

// File: rtl/shreg_serializer.sv
// Parallel-to-serial stage: accepts a word over DV/DR and emits it one bit
// per clock on O with OV/LAST qualifiers, chaining words without a gap.
module shreg_serializer
    import shreg_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             DR,
    output logic             O,
    output logic             OV,
    output logic             LAST
);

    localparam int CW = cnt_bits(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             o_q, o_d;
    logic             ov_q, ov_d;
    logic             dr_q, dr_d;
    logic             transfer;
    logic             cnt_load;
    logic             cnt_en;
    logic             out_bit;
    logic [CW-1:0]    cnt;
    logic             at_last;

    assign transfer = DV & dr_q;

    shreg_bit_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .C      (C),
        .R      (R),
        .load   (cnt_load),
        .en     (cnt_en),
        .cnt    (cnt),
        .at_last(at_last)
    );

    // Every output is registered from next-state values, so DR never sees DV combinationally.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d  = SHIFT;
                    hold_d   = D;
                    cnt_load = 1'b1;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    cnt_load = 1'b1;
                    if (transfer) begin
                        hold_d = D;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_en = 1'b1;
                    hold_d = MSB_FIRST ? (hold_q << 1) : (hold_q >> 1);
                end
            end
        endcase

        out_bit = MSB_FIRST ? hold_d[WIDTH-1] : hold_d[0];
        o_d     = (state_d == SHIFT) & out_bit;
        ov_d    = (state_d == SHIFT);
        dr_d    = (state_d == IDLE) | (cnt_en & (cnt == CW'(WIDTH - 2)));
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= IDLE;
            hold_q  <= '0;
            o_q     <= 1'b0;
            ov_q    <= 1'b0;
            dr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            o_q     <= o_d;
            ov_q    <= ov_d;
            dr_q    <= dr_d;
        end
    end

    assign DR   = dr_q;
    assign O    = o_q;
    assign OV   = ov_q;
    assign LAST = at_last;

endmodule

// File: tb/tb_shreg_serializer.sv
// Scoreboard bench for shreg_serializer: an 8-bit MSB-first instance feeding a
// modelled 8-stage downstream shift register, and a 4-bit LSB-first instance.
module tb_shreg_serializer;
    import shreg_pkg::*;

    typedef struct packed {
        logic o;
        logic last;
    } bit_t;

    logic       clk = 1'b0;
    logic       R;
    logic [7:0] D8;
    logic       DV8, DR8, O8, OV8, LAST8;
    logic [3:0] D4;
    logic       DV4, DR4, O4, OV4, LAST4;
    logic [7:0] ds;

    bit_t q8[$];
    bit_t q4[$];
    int   total = 0;
    int   bad = 0;
    int   ovStarts8 = 0;

    always #5 clk = ~clk;

    shreg_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .C(clk), .R(R), .D(D8), .DV(DV8), .DR(DR8), .O(O8), .OV(OV8), .LAST(LAST8)
    );

    shreg_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .C(clk), .R(R), .D(D4), .DV(DV4), .DR(DR4), .O(O4), .OV(OV4), .LAST(LAST4)
    );

    // Downstream 8-stage serial-in shift register fed by the 8-bit serializer.
    always @(posedge clk) begin
        if (R) ds <= '0;
        else   ds <= {ds[6:0], O8};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus8(input logic [7:0] d, output int waited);
        bit_t e;
        D8 = d;
        DV8 = 1'b1;
        waited = 0;
        @(negedge clk);
        while (DR8 !== 1'b1 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (DR8 !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL accept8 timeout: DR stayed %b, wanted 1", DR8);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                e.o = d[i];
                e.last = (i == 0);
                q8.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus4(input logic [3:0] d, output int waited);
        bit_t e;
        D4 = d;
        DV4 = 1'b1;
        waited = 0;
        @(negedge clk);
        while (DR4 !== 1'b1 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (DR4 !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL accept4 timeout: DR stayed %b, wanted 1", DR4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                e.o = d[i];
                e.last = (i == 3);
                q4.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors pop the scoreboard whenever a valid bit is presented.
    initial begin : mon8
        bit_t e;
        logic prevOv;
        prevOv = 1'b0;
        forever begin
            @(negedge clk);
            if (OV8 === 1'b1) begin
                if (!prevOv) ovStarts8++;
                if (q8.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb8 unexpected bit: got O=%b, wanted no valid bit", O8);
                end else begin
                    e = q8.pop_front();
                    checkOutput("sb8 O", O8, e.o);
                    checkOutput("sb8 LAST", LAST8, e.last);
                end
            end else if (R !== 1'b1) begin
                checkOutput("idle8 O/LAST", {O8, LAST8}, 0);
            end
            prevOv = OV8;
        end
    end

    initial begin : mon4
        bit_t e;
        forever begin
            @(negedge clk);
            if (OV4 === 1'b1) begin
                if (q4.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb4 unexpected bit: got O=%b, wanted no valid bit", O4);
                end else begin
                    e = q4.pop_front();
                    checkOutput("sb4 O", O4, e.o);
                    checkOutput("sb4 LAST", LAST4, e.last);
                end
            end else if (R !== 1'b1) begin
                checkOutput("idle4 O/LAST", {O4, LAST4}, 0);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, wanted finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int n;
        int s;
        logic [7:0] pat;
        R = 1'b1;
        D8 = '0;
        DV8 = 1'b0;
        D4 = '0;
        DV4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset8 O/OV/LAST", {O8, OV8, LAST8}, 0);
        checkOutput("reset8 DR", DR8, 1);
        checkOutput("reset4 O/OV/LAST", {O4, OV4, LAST4}, 0);
        checkOutput("reset4 DR", DR4, 1);
        @(posedge clk);
        #1;
        R = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single word A5, then zeros through the downstream register.
        pat = 8'hA5;
        applyStimulus8(pat, n);
        DV8 = 1'b0;
        checkOutput("A5 accept wait", n, 0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                checkOutput("A5 DR", DR8, (k == 8));
                checkOutput("A5 LAST", LAST8, (k == 8));
                checkOutput("A5 OV", OV8, 1);
            end else begin
                if (k == 9) checkOutput("A5 OV off", OV8, 0);
                checkOutput("downstream out", ds[7], pat[16-k]);
            end
        end
        @(posedge clk);
        #1;

        // Back-to-back FF then 00 with DV held high.
        s = ovStarts8;
        applyStimulus8(8'hFF, n);
        checkOutput("b2b first wait", n, 0);
        applyStimulus8(8'h00, n);
        checkOutput("b2b second wait", n, 7);
        DV8 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("b2b OV runs", ovStarts8 - s, 1);

        // Stall: DV raised mid-word, D changed before acceptance.
        applyStimulus8(8'h3C, n);
        DV8 = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        D8 = 8'h11;
        DV8 = 1'b1;
        @(negedge clk);
        checkOutput("stall DR c3", DR8, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stall DR c4", DR8, 0);
        @(posedge clk);
        #1;
        applyStimulus8(8'h5A, n);
        checkOutput("stall accept wait", n, 3);
        DV8 = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Reset during the 4th bit of C3, then a clean 81.
        applyStimulus8(8'hC3, n);
        DV8 = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        R = 1'b1;
        @(posedge clk);
        #1;
        R = 1'b0;
        checkOutput("reset mid-word bits left", q8.size(), 4);
        q8.delete();
        @(negedge clk);
        checkOutput("mid-reset O/OV/LAST", {O8, OV8, LAST8}, 0);
        checkOutput("mid-reset DR", DR8, 1);
        @(posedge clk);
        #1;
        applyStimulus8(8'h81, n);
        checkOutput("81 accept wait", n, 0);
        DV8 = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // LSB-first 4-bit instance, two words back to back.
        applyStimulus4(4'b0001, n);
        checkOutput("w4 first wait", n, 0);
        applyStimulus4(4'b1010, n);
        checkOutput("w4 second wait", n, 3);
        DV4 = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        checkOutput("sb8 drained", q8.size(), 0);
        checkOutput("sb4 drained", q4.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shreg_serializer.md
Name: shreg_serializer

Overview:
- Parallel-to-serial stage that feeds the single-bit data input of the downstream 8-stage shift register (serial in, MSB-first shift).
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on O, with a qualifier (OV) and an end-of-word marker (LAST).
- Supports back-to-back words with no bubble cycle, so the downstream shift register can be kept continuously filled.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = D[WIDTH-1] shifted out first, 0 = D[0] first.

Ports:
- C  input  1  clock, rising edge.
- R  input  1  synchronous active-high reset.
- D  input  WIDTH  parallel word; sampled only on an accepted transfer.
- DV  input  1  upstream word valid.
- DR  output  1  ready to accept a word.
- O  output  1  serial data bit.
- OV  output  1  O carries a valid bit this cycle.
- LAST  output  1  current bit on O is the final bit of its word.

Behaviour:
- Reset: R sampled high at a rising C gives state IDLE, O=0, OV=0, LAST=0, DR=1, counter=0, holding register=0. R overrides all other inputs. A reset mid-word aborts that word; its remaining bits are never emitted.
- Transfer: occurs at a rising C with DV=1 and DR=1. D is captured in the same edge.
- DV=1 with DR=0 is ignored; upstream must hold D and DV until accepted.
- States: IDLE and SHIFT.
  - IDLE: DR=1, OV=0, O=0, LAST=0. On a transfer, go to SHIFT with counter=0.
  - SHIFT: OV=1, O = bit [counter] of the word in transmission order. Counter increments by 1 each cycle.
  - LAST=1 when counter==WIDTH-1.
  - DR=1 only when counter==WIDTH-1; DR=0 otherwise.
- End of word (counter==WIDTH-1):
  - If a transfer occurs, stay in SHIFT, reload the holding register, set counter=0. The next cycle shows bit 0 of the new word, so there is no gap.
  - Otherwise go to IDLE.
- Latency: the first bit appears on O in the cycle after the transfer edge (1-cycle latency). A word occupies exactly WIDTH consecutive cycles.
- Throughput: 1 word per WIDTH cycles when DV is held high.
- Implementation:
  - Holding register shifts by one position per cycle: left when MSB_FIRST=1, right when MSB_FIRST=0. O is driven from the outgoing end.
  - Counter width is clog2(WIDTH); it never exceeds WIDTH-1.
- DR is a registered output derived from the next state and next counter value. There is no combinational path from DV to DR.
- All outputs are registered; there are no latches.

Decomposition:
- Package shreg_pkg holds:
  - state enum {IDLE, SHIFT};
  - localparam DEFAULT_WIDTH=8;
  - function cnt_bits(width) returning clog2(width).
- One sub-module is natural: shreg_bit_counter. It has ports C, R, load, en, and outputs cnt and at_last. It is a wrap-free up-counter with a registered terminal flag.
- The top level holds the FSM, the holding register and the handshake logic.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1: D=8'hA5 with DV pulsed for 1 cycle. Required on O over cycles t+1..t+8: 1,0,1,0,0,1,0,1. OV high for exactly those 8 cycles, LAST high only at t+8, DR low t+1..t+7 and high at t+8.
- Back-to-back: DV held high with D=8'hFF then 8'h00. Required: O gives 8 ones then 8 zeros with OV continuously 1 (no bubble). LAST pulses at cycles 8 and 16; DR accepted at cycle 8 only.
- Stall: DV=1 asserted at cycle t+3 while busy. Required: word not accepted until the LAST cycle t+8. D changes before t+8 have no effect on the current word.
- Reset mid-word: R=1 at the 4th bit of 8'hC3. Next cycle: O=0, OV=0, LAST=0, DR=1. A following word 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
- MSB_FIRST=0, WIDTH=4: D=4'b0001. Required O sequence is 1,0,0,0, with LAST on the 4th bit.
- Chained with the downstream 8-bit shift stage: stream 8'hA5 once, then zeros. Downstream output shows 1,0,1,0,0,1,0,1 beginning 8 cycles after the first O bit (9 after the transfer edge).
